// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_pkg
//  Description : Shared types and index constants for the byte serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package serializer_pkg;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Lowest and highest bit index of the held byte.
  localparam logic [2:0] FIRST_IDX = 3'd0;
  localparam logic [2:0] LAST_IDX  = 3'd7;

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/serializer8_mux8.sv
`default_nettype none
// ============================================================================
//  Module      : mux8
//  Description : 8:1 single-bit multiplexer, y = d[s].
//  Revision    : 1.0  initial release
// ============================================================================
module mux8 (
  input  logic [2:0] s,
  input  logic [7:0] d,
  output logic       y
);

  // Pick one bit of the data word according to the select index.
  always_comb begin
    y = 1'b0;
    case (s)
      3'd0:    y = d[0];
      3'd1:    y = d[1];
      3'd2:    y = d[2];
      3'd3:    y = d[3];
      3'd4:    y = d[4];
      3'd5:    y = d[5];
      3'd6:    y = d[6];
      default: y = d[7];
    endcase
  end

endmodule : mux8
`default_nettype wire

// File: rtl/serializer8.sv
`default_nettype none
// ============================================================================
//  Module      : serializer8
//  Description : Byte-to-bit serializer with valid/ready on both sides.
//                Sustains one bit per cycle across back-to-back bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module serializer8
  import serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [2:0] sel
);

  // Index of the first and the final bit sent for the chosen bit order.
  localparam logic [2:0] START_IDX = MSB_FIRST ? LAST_IDX  : FIRST_IDX;
  localparam logic [2:0] STOP_IDX  = MSB_FIRST ? FIRST_IDX : LAST_IDX;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold;
  logic [7:0] hold_nxt;
  logic [2:0] sel_nxt;
  logic       accept;
  logic       xfer;

  // Handshake outputs; in_ready looks through to out_ready so a new byte
  // can load on the same edge that the final bit leaves.
  always_comb begin
    out_valid = (state == SHIFT);
    out_last  = out_valid && (sel == STOP_IDX);
    in_ready  = (state == IDLE) || (out_last && out_ready);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  // Next state, hold register and bit index; stalls keep everything as is.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    sel_nxt   = sel;
    if (accept) begin
      // Covers both a fresh start from IDLE and a gapless reload on the
      // final bit of the previous byte.
      state_nxt = SHIFT;
      hold_nxt  = in_data;
      sel_nxt   = START_IDX;
    end else if (xfer) begin
      if (out_last) begin
        state_nxt = IDLE;
        sel_nxt   = START_IDX;
      end else if (MSB_FIRST) begin
        sel_nxt = sel - 3'd1;
      end else begin
        sel_nxt = sel + 3'd1;
      end
    end
  end

  // Single register process for state, held byte and index; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= 8'h00;
      sel   <= START_IDX;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      sel   <= sel_nxt;
    end
  end

  // Current serial bit is the held byte indexed by sel, no extra latency.
  mux8 u_mux8 (
    .s (sel),
    .d (hold),
    .y (out_bit)
  );

endmodule : serializer8
`default_nettype wire
